// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 load/store unit.
// Holds the opcode constants, the effective-address operand select
// encodings driven to the EA adder, and the access FSM state type.
package lc3_pkg;

  // Load opcodes (IR[15:12])
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LEA = 4'b1110;

  // Store opcodes (IR[15:12])
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_STR = 4'b0111;

  // EA adder operand selects
  localparam logic [2:0] EA_SEL_NONE      = 3'b000;
  localparam logic [2:0] EA_SEL_PC_OFF9   = 3'b010;
  localparam logic [2:0] EA_SEL_BASE_OFF6 = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    IND,
    ACCESS,
    FINISH
  } state_e;

endpackage

// File: rtl/lsu_decode.sv
// Opcode decoder for the load/store unit.
// Ports:
//   opcode      in   4  instruction opcode field IR[15:12]
//   is_load     out  1  LD, LDI, LDR or LEA
//   is_store    out  1  ST, STI or STR
//   is_indirect out  1  LDI or STI (extra pointer read)
//   is_lea      out  1  LEA (address only, no memory access)
//   is_legal    out  1  any of the seven load/store opcodes
//   ea_sel      out  3  operand select for the EA adder
module lsu_decode
  import lc3_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_indirect,
  output logic       is_lea,
  output logic       is_legal,
  output logic [2:0] ea_sel
);

  always_comb begin
    is_load     = 1'b0;
    is_store    = 1'b0;
    is_indirect = 1'b0;
    is_lea      = 1'b0;
    ea_sel      = EA_SEL_NONE;
    unique case (opcode)
      OP_LD:  begin is_load = 1'b1; ea_sel = EA_SEL_PC_OFF9; end
      OP_LDI: begin is_load = 1'b1; is_indirect = 1'b1; ea_sel = EA_SEL_PC_OFF9; end
      OP_LDR: begin is_load = 1'b1; ea_sel = EA_SEL_BASE_OFF6; end
      OP_LEA: begin is_load = 1'b1; is_lea = 1'b1; ea_sel = EA_SEL_PC_OFF9; end
      OP_ST:  begin is_store = 1'b1; ea_sel = EA_SEL_PC_OFF9; end
      OP_STI: begin is_store = 1'b1; is_indirect = 1'b1; ea_sel = EA_SEL_PC_OFF9; end
      OP_STR: begin is_store = 1'b1; ea_sel = EA_SEL_BASE_OFF6; end
      default: ;
    endcase
    is_legal = is_load | is_store;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// LC-3 memory access controller: sequences LD/LDI/LDR/LEA/ST/STI/STR
// through effective-address capture, optional pointer read and one
// memory transfer, then strobes the register file for loads.
// Optional feature macro: LC3_MEM_TIMEOUT_EN (per-request timeout that
// aborts the access with an ERROR pulse).
// Ports:
//   CLK, RESET (async, active-high)
//   START/IR/STORE_DATA  command in (START is a one-cycle pulse)
//   EA / EA_CONTROL      EA adder result in / operand select out
//   MEM_REQ/WE/ADDR/WDATA, MEM_READY/RDATA  memory handshake
//   LOAD_EN/DR/DATA      register-file write port
//   BUSY, DONE, ERROR    status
module mem_access_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [15:0] IR,
  input  logic [15:0] STORE_DATA,
  input  logic [15:0] EA,
  output logic [2:0]  EA_CONTROL,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  output logic [15:0] MEM_WDATA,
  input  logic        MEM_READY,
  input  logic [15:0] MEM_RDATA,
  output logic        LOAD_EN,
  output logic [2:0]  LOAD_DR,
  output logic [15:0] LOAD_DATA,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] sd_q, sd_d;
  logic [15:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] ldata_q, ldata_d;
  logic        err_q, err_d;
  logic        hs;

  // Decode of the incoming IR, used only for the legality check at START.
  logic       st_load, st_store, st_ind, st_lea, st_legal;
  logic [2:0] st_sel;
  // Decode of the latched IR, drives sequencing and EA_CONTROL.
  logic       cur_load, cur_store, cur_ind, cur_lea, cur_legal;
  logic [2:0] cur_sel;

  lsu_decode u_dec_start (
    .opcode      (IR[15:12]),
    .is_load     (st_load),
    .is_store    (st_store),
    .is_indirect (st_ind),
    .is_lea      (st_lea),
    .is_legal    (st_legal),
    .ea_sel      (st_sel)
  );

  lsu_decode u_dec_cur (
    .opcode      (ir_q[15:12]),
    .is_load     (cur_load),
    .is_store    (cur_store),
    .is_indirect (cur_ind),
    .is_lea      (cur_lea),
    .is_legal    (cur_legal),
    .ea_sel      (cur_sel)
  );

  logic unused_dec;
  assign unused_dec = ^{st_load, st_store, st_ind, st_lea, st_sel, cur_legal, ir_q[8:0]};

  assign hs = req_q & MEM_READY;

`ifdef LC3_MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_q, to_d;
  logic            to_hit;
  assign to_hit = req_q & ~MEM_READY & (to_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_to_cfg = TIMEOUT_CYCLES + TO_W;
`endif

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    sd_d    = sd_q;
    addr_d  = addr_q;
    req_d   = req_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    err_d   = 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
    to_d    = to_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (START) begin
          ir_d = IR;
          sd_d = STORE_DATA;
          if (st_legal) state_d = CALC;
          else          err_d   = 1'b1;
        end
      end
      CALC: begin
        addr_d = EA;
        if (cur_lea) begin
          ldata_d = EA;
          state_d = FINISH;
        end else begin
          // First request: pointer read for indirect forms, otherwise the
          // actual transfer.
          req_d   = 1'b1;
          we_d    = cur_store & ~cur_ind;
          wdata_d = (cur_store & ~cur_ind) ? sd_q : '0;
`ifdef LC3_MEM_TIMEOUT_EN
          to_d    = '0;
`endif
          state_d = cur_ind ? IND : ACCESS;
        end
      end
      IND: begin
        if (hs) begin
          // Pointer arrives; the data transfer is issued back-to-back so
          // MEM_REQ stays high into ACCESS with the new address.
          addr_d  = MEM_RDATA;
          req_d   = 1'b1;
          we_d    = cur_store;
          wdata_d = cur_store ? sd_q : '0;
`ifdef LC3_MEM_TIMEOUT_EN
          to_d    = '0;
`endif
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (hs) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wdata_d = '0;
          if (cur_load) ldata_d = MEM_RDATA;
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef LC3_MEM_TIMEOUT_EN
    if ((state_q == IND || state_q == ACCESS) && req_q && !MEM_READY) begin
      to_d = to_q + 1'b1;
      if (to_hit) begin
        req_d   = 1'b0;
        we_d    = 1'b0;
        wdata_d = '0;
        err_d   = 1'b1;
        state_d = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      ir_q    <= '0;
      sd_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ldata_q <= '0;
      err_q   <= 1'b0;
`ifdef LC3_MEM_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      sd_q    <= sd_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      err_q   <= err_d;
`ifdef LC3_MEM_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  assign EA_CONTROL = cur_sel;
  assign MEM_REQ    = req_q;
  assign MEM_WE     = we_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_WDATA  = wdata_q;
  assign LOAD_DR    = ir_q[11:9];
  assign LOAD_DATA  = ldata_q;
  assign BUSY       = (state_q != IDLE);
  assign DONE       = (state_q == FINISH);
  assign LOAD_EN    = (state_q == FINISH) & cur_load;
  assign ERROR      = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic [15:0] IR, STORE_DATA, EA;
  logic [2:0]  EA_CONTROL;
  logic        MEM_REQ, MEM_WE;
  logic [15:0] MEM_ADDR, MEM_WDATA;
  logic        MEM_READY;
  logic [15:0] MEM_RDATA;
  logic        LOAD_EN;
  logic [2:0]  LOAD_DR;
  logic [15:0] LOAD_DATA;
  logic        BUSY, DONE, ERROR;

  mem_access_ctrl #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .IR(IR), .STORE_DATA(STORE_DATA),
    .EA(EA), .EA_CONTROL(EA_CONTROL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_READY(MEM_READY),
    .MEM_RDATA(MEM_RDATA), .LOAD_EN(LOAD_EN), .LOAD_DR(LOAD_DR),
    .LOAD_DATA(LOAD_DATA), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Results of the last operation
  int          lat, n_hs, stab_err, err_cnt, wcnt;
  bit          done_seen, le_seen, req_live;
  logic [2:0]  ea_ctrl, le_dr;
  logic [15:0] le_data;
  logic [15:0] hs_addr [4];
  logic        hs_we   [4];
  logic [15:0] hs_wdata[4];
  logic [15:0] p_addr, p_wdata;
  logic        p_we;

  function automatic logic [63:0] all_outs();
    return 64'({MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, LOAD_EN, LOAD_DR,
                LOAD_DATA, DONE, BUSY, ERROR, EA_CONTROL});
  endfunction

  // Runs one command. nwait = READY-low cycles per request; abort_at > 0
  // asserts RESET at that cycle; restart re-pulses START (illegal IR) at cycle 2.
  task automatic do_op(input logic [15:0] ir, input logic [15:0] sd,
                       input logic [15:0] ea, input logic [15:0] rdata,
                       input int nwait, input int max_lat, input int abort_at,
                       input bit restart, input bit expect_done);
    bit aborted = 0;
    lat = 0; n_hs = 0; stab_err = 0; err_cnt = 0; wcnt = 0;
    done_seen = 0; le_seen = 0; req_live = 0; ea_ctrl = '0; le_dr = '0; le_data = '0;
    EA = ea; MEM_RDATA = rdata;
    @(posedge CLK); #1;
    START = 1'b1; IR = ir; STORE_DATA = sd;
    while (!done_seen && !aborted && lat < max_lat) begin
      @(posedge CLK); lat++;
      @(negedge CLK);
      START = restart && (lat == 2);
      if (restart && lat == 2) IR = 16'hD000;
      if (lat == 1) ea_ctrl = EA_CONTROL;
      if (ERROR) err_cnt++;
      if (LOAD_EN) begin le_seen = 1; le_dr = LOAD_DR; le_data = LOAD_DATA; end
      if (DONE) done_seen = 1;
      if (MEM_REQ) begin
        if (!req_live) begin
          req_live = 1; p_addr = MEM_ADDR; p_we = MEM_WE; p_wdata = MEM_WDATA;
        end else if (MEM_ADDR !== p_addr || MEM_WE !== p_we || MEM_WDATA !== p_wdata) begin
          stab_err++;
        end
        if (wcnt < nwait) begin
          MEM_READY = 1'b0; wcnt++;
        end else begin
          MEM_READY = 1'b1;
          if (n_hs < 4) begin
            hs_addr[n_hs] = MEM_ADDR; hs_we[n_hs] = MEM_WE; hs_wdata[n_hs] = MEM_WDATA;
          end
          n_hs++; req_live = 0; wcnt = 0;
        end
      end else begin
        MEM_READY = 1'b1;
        req_live = 0;
      end
      if (abort_at == lat) begin
        check("pre_reset_busy_req", {BUSY, MEM_REQ}, 2'b11);
        RESET = 1'b1;
        #1;
        check("reset_mid_outputs", all_outs(), 64'd0);
        aborted = 1;
      end
    end
    START = 1'b0;
    MEM_READY = 1'b1;
    if (expect_done && !done_seen) check("done_bound", 64'(lat), 64'(max_lat + 1));
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; IR = '0; STORE_DATA = '0; EA = '0;
    MEM_READY = 1'b1; MEM_RDATA = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", all_outs(), 64'd0);
    RESET = 1'b0;

    // LD R1: read at 3005 returns BEEF
    do_op(16'h2205, 16'h0000, 16'h3005, 16'hBEEF, 0, 20, 0, 0, 1);
    check("ld_latency", 64'(lat), 64'd3);
    check("ld_ea_ctrl", 64'(ea_ctrl), 64'h2);
    check("ld_n_hs", 64'(n_hs), 64'd1);
    check("ld_addr_we", {hs_addr[0], hs_we[0]}, {16'h3005, 1'b0});
    check("ld_load", {le_seen, le_dr, le_data}, {1'b1, 3'd1, 16'hBEEF});
    check("ld_no_err", 64'(err_cnt), 64'd0);

    // STI: pointer read at 4000 -> 5000, write 1234 there
    do_op(16'hB1FF, 16'h1234, 16'h4000, 16'h5000, 0, 20, 0, 0, 1);
    check("sti_latency", 64'(lat), 64'd4);
    check("sti_ea_ctrl", 64'(ea_ctrl), 64'h2);
    check("sti_n_hs", 64'(n_hs), 64'd2);
    check("sti_rd", {hs_addr[0], hs_we[0]}, {16'h4000, 1'b0});
    check("sti_wr", {hs_addr[1], hs_we[1], hs_wdata[1]}, {16'h5000, 1'b1, 16'h1234});
    check("sti_no_load", 64'(le_seen), 64'd0);

    // STR with 5 wait cycles
    do_op(16'h7E3F, 16'hABCD, 16'h1111, 16'h0000, 5, 30, 0, 0, 1);
    check("str_latency", 64'(lat), 64'd8);
    check("str_ea_ctrl", 64'(ea_ctrl), 64'h5);
    check("str_stable", 64'(stab_err), 64'd0);
    check("str_wr", {hs_addr[0], hs_we[0], hs_wdata[0]}, {16'h1111, 1'b1, 16'hABCD});

    // LDR R5 with 2 waits, plus a START (illegal IR) while busy that must be ignored
    do_op(16'h6A81, 16'h0000, 16'h8000, 16'h1357, 2, 30, 0, 1, 1);
    check("ldr_latency", 64'(lat), 64'd5);
    check("ldr_ea_ctrl", 64'(ea_ctrl), 64'h5);
    check("ldr_load", {le_seen, le_dr, le_data}, {1'b1, 3'd5, 16'h1357});
    check("busy_start_ignored", 64'(err_cnt), 64'd0);

    // LEA R0 at FFFF: no memory access
    do_op(16'hE1FF, 16'h0000, 16'hFFFF, 16'h0000, 0, 20, 0, 0, 1);
    check("lea_latency", 64'(lat), 64'd2);
    check("lea_load", {le_seen, le_dr, le_data, 8'(n_hs)}, {1'b1, 3'd0, 16'hFFFF, 8'd0});

    // Illegal opcode
    begin
      int e = 0, b = 0, r = 0;
      @(posedge CLK); #1; START = 1'b1; IR = 16'hD000;
      for (int i = 0; i < 4; i++) begin
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        if (ERROR) e++;
        if (BUSY) b++;
        if (MEM_REQ) r++;
      end
      check("illegal_err_pulses", 64'(e), 64'd1);
      check("illegal_busy_req", {32'(b), 32'(r)}, 64'd0);
    end

    // Reset during IND of an LDI (pointer read never acknowledged)
    do_op(16'hA400, 16'h0000, 16'h2000, 16'h0000, 50, 20, 2, 0, 0);
    begin
      int bad = 0;
      for (int i = 0; i < 3; i++) begin
        @(posedge CLK);
        @(negedge CLK);
        if (DONE || LOAD_EN) bad++;
        if (i == 1) RESET = 1'b0;
      end
      check("reset_no_done", 64'(bad), 64'd0);
    end
    // LEA after reset, EA wrapped to 0000
    do_op(16'hE1FF, 16'h0000, 16'h0000, 16'h0000, 0, 20, 0, 0, 1);
    check("lea_after_reset_latency", 64'(lat), 64'd2);
    check("lea_after_reset_load", {le_seen, le_data}, {1'b1, 16'h0000});

`ifdef LC3_MEM_TIMEOUT_EN
    // READY held low: request aborted after 4 waiting cycles
    do_op(16'h2205, 16'h0000, 16'h3005, 16'hBEEF, 1000, 10, 0, 0, 0);
    check("to_err_pulses", 64'(err_cnt), 64'd1);
    check("to_no_done_load", {done_seen, le_seen}, 2'b00);
    check("to_idle_after", {BUSY, MEM_REQ}, 2'b00);
`else
    // No timeout: waits indefinitely and completes normally
    do_op(16'h2205, 16'h0000, 16'h3005, 16'hCAFE, 20, 40, 0, 0, 1);
    check("long_wait_latency", 64'(lat), 64'd23);
    check("long_wait_no_err", 64'(err_cnt), 64'd0);
    check("long_wait_load", {le_seen, le_data}, {1'b1, 16'hCAFE});
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: CLK is the single clock, and RESET is asynchronous and active-high.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- TIMEOUT_CYCLES, 255, maximum number of cycles to wait for MEM_READY on one access.
- TO_W, 8, width of the timeout counter.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, clock.
- RESET, in, 1, asynchronous reset, active-high.
- START, in, 1, one-cycle pulse; IR and STORE_DATA are valid.
- IR, in, 16, instruction word.
- STORE_DATA, in, 16, SR register contents for stores.
- EA, in, 16, result from the effective-address adder.
- EA_CONTROL, out, 3, operand select to the effective-address adder.
- MEM_REQ, out, 1, memory request.
- MEM_WE, out, 1, write enable; 1 means write.
- MEM_ADDR, out, 16, memory address.
- MEM_WDATA, out, 16, memory write data.
- MEM_READY, in, 1, memory acknowledge.
- MEM_RDATA, in, 16, memory read data.
- LOAD_EN, out, 1, one-cycle register-file write strobe.
- LOAD_DR, out, 3, destination register (IR[11:9]).
- LOAD_DATA, out, 16, register-file write data.
- BUSY, out, 1, high whenever the FSM is not in IDLE.
- DONE, out, 1, one-cycle completion pulse.
- ERROR, out, 1, one-cycle pulse on an illegal opcode or a timeout.

Function
REQ-004 On START in IDLE, the block SHALL latch IR and STORE_DATA and decode IR[15:12]:
- LD=0010, LDI=1010, LDR=0110, LEA=1110: loads.
- ST=0011, STI=1011, STR=0111: stores.
- Any other opcode: illegal.
REQ-005 EA_CONTROL SHALL be driven combinationally from the latched IR:
- LD, LDI, ST, STI, LEA: 3'b010 (PC + sext(IR[8:0])).
- LDR, STR: 3'b101 (base register + sext(IR[5:0])).
- Otherwise: 3'b000.
REQ-006 The FSM SHALL have the states IDLE, CALC, IND, ACCESS and FINISH.
REQ-007 From IDLE, on START:
- Legal opcode: go to CALC.
- Illegal opcode: pulse ERROR for one cycle and stay in IDLE.
REQ-008 START while BUSY SHALL be ignored.
REQ-009 In CALC, the block SHALL register EA into an internal address register, then go to:
- IND for LDI and STI;
- FINISH for LEA (LOAD_DATA = EA, no memory access);
- ACCESS for all other opcodes.
REQ-010 In IND, the block SHALL issue a read (MEM_WE=0) at the registered address, replace the address register with MEM_RDATA on handshake, and then go to ACCESS.
REQ-011 In ACCESS, the block SHALL issue one transfer at the address register:
- Loads: MEM_WE=0; LOAD_DATA is latched from MEM_RDATA on handshake.
- Stores: MEM_WE=1 and MEM_WDATA = latched STORE_DATA.
- After the handshake, go to FINISH.
REQ-012 A handshake SHALL be the cycle in which MEM_REQ=1 and MEM_READY=1.
REQ-013 While a request is pending, MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA SHALL be registered and held stable until the handshake.
REQ-014 MEM_REQ SHALL deassert in the cycle after the handshake.
REQ-015 In FINISH, the block SHALL pulse DONE for one cycle and, for loads including LEA, pulse LOAD_EN in the same cycle, then return to IDLE.
REQ-016 Latency from START to DONE, with MEM_READY held high, SHALL be:
- LEA: 2 cycles.
- LD, LDR, ST, STR: 3 cycles.
- LDI, STI: 4 cycles.
- Each wait cycle adds 1.
REQ-017 All EA arithmetic is 16-bit and wraps modulo 2^16; the block SHALL NOT treat overflow as an error.
REQ-018 MEM_READY asserted while MEM_REQ=0 SHALL be ignored.

Reset
REQ-019 When RESET asserts, the block SHALL go to IDLE immediately, even mid-access.
REQ-020 When RESET asserts, the block SHALL clear to 0: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, LOAD_EN, LOAD_DATA, LOAD_DR, DONE, BUSY, ERROR, the latched IR, the address register and the timeout counter.
REQ-021 The block SHALL NOT produce a DONE or LOAD_EN for an access interrupted by RESET.

Configuration
REQ-022 With LC3_MEM_TIMEOUT_EN defined:
- A TO_W-bit counter clears when each request is issued and increments every cycle MEM_REQ=1 without MEM_READY.
- When the counter reaches TIMEOUT_CYCLES, the block drops MEM_REQ, pulses ERROR for one cycle, suppresses DONE and LOAD_EN, and returns to IDLE.
REQ-023 Without LC3_MEM_TIMEOUT_EN, no counter SHALL exist, the block SHALL wait indefinitely, and ERROR SHALL pulse only for illegal opcodes.

Structure
REQ-024 A shared package lc3_pkg SHALL hold:
- the opcode constants;
- the EA_CONTROL encodings EA_SEL_PC_OFF9=3'b010 and EA_SEL_BASE_OFF6=3'b101;
- the FSM state type.
REQ-025 Opcode decoding SHALL live in one sub-module, lsu_decode, which takes the opcode and outputs is_load, is_store, is_indirect, is_lea, is_legal and ea_sel.

Verification
REQ-026 LD: IR=16'h2205, EA=16'h3005, MEM_READY=1, MEM_RDATA=16'hBEEF -> EA_CONTROL=3'b010, one read at 16'h3005, LOAD_EN with LOAD_DR=1 and LOAD_DATA=16'hBEEF, DONE 3 cycles after START.
REQ-027 STI: IR=16'hB1FF, EA=16'h4000, first read returns 16'h5000, STORE_DATA=16'h1234 -> read at 16'h4000, then write at 16'h5000 with WDATA 16'h1234, no LOAD_EN, DONE at cycle 4.
REQ-028 STR: IR=16'h7E3F, MEM_READY low for 5 cycles -> MEM_ADDR, MEM_WDATA and MEM_WE held stable throughout, DONE at cycle 8.
REQ-029 Illegal opcode: IR=16'hD000 -> ERROR pulses one cycle, BUSY stays 0, no MEM_REQ.
REQ-030 Reset mid-operation: RESET asserted during IND of an LDI -> all outputs 0 in the same cycle; a later LEA, IR=16'hE1FF with EA=16'h0000 after wrap, gives LOAD_DATA=16'h0000 with DONE at cycle 2.
REQ-031 Timeout: with LC3_MEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4 and MEM_READY held 0 -> ERROR pulses, MEM_REQ drops, no DONE, BUSY=0 afterwards.
